// File: rtl/icache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module  : icache_direct_mapped
// Brief   : Direct-mapped read-only instruction cache, 128-bit lines, busywait refill
// Revision: 1.0
// ============================================================================
module icache_direct_mapped #(
    parameter int NUM_LINES = 8,
    parameter int TAG_W     = 25
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          read,
    input  logic [31:0]   address,
    output logic [31:0]   instruction,
    output logic          busywait,
    input  logic          flush,
    output logic          mem_read,
    output logic [27:0]   mem_address,
    input  logic [127:0]  mem_readdata,
    input  logic          mem_busywait
);

    localparam int IDX = $clog2(NUM_LINES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [NUM_LINES-1:0]  r_valid;
    logic [TAG_W-1:0]      r_tag  [NUM_LINES];
    logic [127:0]          r_data [NUM_LINES];
    logic [IDX-1:0]        r_miss_idx;
    logic [TAG_W-1:0]      r_miss_tag;
    logic                  r_flush_pend;

    logic [IDX-1:0]        w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic                  w_hit;
    logic                  w_unused_addr_bits;

    assign w_idx              = address[4+IDX-1:4];
    assign w_tag              = address[31:4+IDX];
    assign w_hit              = read && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_unused_addr_bits = &{1'b0, address[1:0]};

    assign instruction = r_data[w_idx][{address[3:2], 5'b00000} +: 32];

    always_comb begin
        w_next_state = r_state;
        busywait     = 1'b0;
        mem_read     = 1'b0;
        mem_address  = '0;
        case (r_state)
            S_IDLE: begin
                // Flush wins over a miss: the access stalls but no fetch starts.
                if (flush) begin
                    busywait = read;
                end else if (read && !w_hit) begin
                    busywait     = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                busywait    = 1'b1;
                mem_read    = 1'b1;
                mem_address = {r_miss_tag, r_miss_idx};
                if (!mem_busywait) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                busywait     = 1'b1;
                mem_address  = {r_miss_tag, r_miss_idx};
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (reset) begin
            w_next_state = S_IDLE;
            busywait     = read;
            mem_read     = 1'b0;
            mem_address  = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_miss_idx   <= '0;
            r_miss_tag   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end else if (read && !w_hit) begin
                        r_miss_idx <= w_idx;
                        r_miss_tag <= w_tag;
                    end
                end
                S_FETCH: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                S_FILL: begin
                    // A flush seen during the refill also discards the line just filled.
                    if (flush || r_flush_pend) begin
                        r_valid      <= '0;
                        r_flush_pend <= 1'b0;
                    end else begin
                        r_valid[r_miss_idx] <= 1'b1;
                    end
                end
                default: begin
                    r_flush_pend <= 1'b0;
                end
            endcase
        end
    end

    // Memory commits its last byte on the edge it drops busywait, so data lands one cycle later.
    always_ff @(posedge clock) begin
        if (r_state == S_FILL) begin
            r_tag[r_miss_idx]  <= r_miss_tag;
            r_data[r_miss_idx] <= mem_readdata;
        end
    end

endmodule
`default_nettype wire
